tx_uart_cfg: RTL and testbench

TX_UART_CFG -- requirements
Module: tx_uart_cfg

---
 rtl/tx_uart_cfg.sv | 209 ++++++++++++++++++++
 tb/tb_tx_uart_cfg.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart_cfg.sv
// ---------------------------------------------------------------------------
// tx_uart_cfg -- configurable UART transmitter with a one-deep holding register
// and a run-time loadable baud divisor.
//
// Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits(1). Each bit lasts 'divisor' clock cycles.
//
// Ports
//   clk           sole clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_valid       word offered; accepted when o_ready is also high
//   i_data        word to transmit (DATA_BITS wide)
//   o_ready       holding register empty, a word can be accepted
//   i_baud_load   request to load i_baud_div (honoured only when idle, empty)
//   i_baud_div    new clocks-per-bit value (values below 2 are ignored)
//   o_busy        frame in progress or word pending
//   o_state       0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
//   uart_rxd_out  registered serial line, idle high
// ---------------------------------------------------------------------------
module tx_uart_cfg #(
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int TIMER_BITS      = 32,
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [DATA_BITS-1:0]  i_data,
    output logic                  o_ready,
    input  logic                  i_baud_load,
    input  logic [TIMER_BITS-1:0] i_baud_div,
    output logic                  o_busy,
    output logic [2:0]            o_state,
    output logic                  uart_rxd_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [TIMER_BITS-1:0] T_ZERO    = '0;
    localparam logic [TIMER_BITS-1:0] T_ONE     = TIMER_BITS'(1);
    localparam logic [TIMER_BITS-1:0] T_TWO     = TIMER_BITS'(2);
    localparam logic [TIMER_BITS-1:0] T_RESET   = TIMER_BITS'(CLOCKS_PER_BAUD);
    localparam logic [3:0]            LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]            LAST_STOP = 4'(STOP_BITS - 1);

    state_t                state_q, state_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [TIMER_BITS-1:0] div_q, div_d;
    logic                  line_q, line_d;

    logic                  accept;
    logic                  bit_end;
    logic                  last_data;
    logic                  last_stop;
    logic                  frame_end;
    logic                  start_frame;
    logic                  div_load;
    logic [TIMER_BITS-1:0] div_eff;
    logic [DATA_BITS-1:0]  next_word;

    // Odd parity: data+parity has an odd number of ones; even: an even number.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~(^d);
        end
        return ^d;
    endfunction

    always_comb begin
        accept    = i_valid & ~hold_full_q;
        bit_end   = (timer_q == T_ZERO);
        last_data = (bit_cnt_q == LAST_DATA);
        last_stop = (bit_cnt_q == LAST_STOP);
        frame_end = (state_q == S_STOP) & bit_end & last_stop;
        // A new frame starts from IDLE or straight out of the final stop bit.
        // A word accepted at that moment bypasses the holding register.
        start_frame = ((state_q == S_IDLE) | frame_end) & (hold_full_q | accept);
        next_word   = hold_full_q ? hold_data_q : i_data;
        div_load    = i_baud_load & (state_q == S_IDLE) & ~hold_full_q &
                      (i_baud_div >= T_TWO);
        // A load coinciding with a frame start already applies to that frame.
        div_eff     = div_load ? i_baud_div : div_q;
    end

    // State register and control flops
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 4'd0;
            timer_q     <= T_ZERO;
            div_q       <= T_RESET;
            line_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            div_q       <= div_d;
            line_q      <= line_d;
        end
    end

    // Data payload flops; only meaningful while qualified by the control state
    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
        shift_q     <= shift_d;
        par_q       <= par_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_frame) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA:   if (bit_end && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (frame_end) state_d = start_frame ? S_START : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and line next values
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        div_d       = div_eff;
        line_d      = line_q;

        if (start_frame) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = i_data;
        end

        if (start_frame) begin
            shift_d   = next_word;
            par_d     = parity_bit(next_word);
            bit_cnt_d = 4'd0;
            timer_d   = div_eff - T_ONE;
            line_d    = 1'b0;
        end else if (state_q != S_IDLE) begin
            if (bit_end) begin
                timer_d = div_q - T_ONE;
                unique case (state_q)
                    S_START: begin
                        bit_cnt_d = 4'd0;
                        line_d    = shift_q[0];
                    end
                    S_DATA: begin
                        if (last_data) begin
                            bit_cnt_d = 4'd0;
                            line_d    = (PARITY != 0) ? par_q : 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            shift_d   = shift_q >> 1;
                            line_d    = shift_q[1];
                        end
                    end
                    S_PARITY: begin
                        bit_cnt_d = 4'd0;
                        line_d    = 1'b1;
                    end
                    S_STOP: begin
                        line_d = 1'b1;
                        if (last_stop) begin
                            // Frame over with nothing queued: park the timer.
                            bit_cnt_d = 4'd0;
                            timer_d   = T_ZERO;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    default: line_d = 1'b1;
                endcase
            end else begin
                timer_d = timer_q - T_ONE;
            end
        end
    end

    // Outputs
    always_comb begin
        o_ready      = ~hold_full_q;
        o_busy       = (state_q != S_IDLE) | hold_full_q;
        o_state      = state_q;
        uart_rxd_out = line_q;
    end

endmodule

// File: tb/tb_tx_uart_cfg.sv
module tb_tx_uart_cfg;

    logic        clk;
    logic        rst_n;
    logic [3:0]  val;
    logic [3:0]  bl;
    logic [7:0]  dv;
    logic [31:0] bd;
    logic [3:0]  rdy;
    logic [3:0]  busy;
    logic [3:0]  rxd;
    logic [2:0]  st [4];

    int checks = 0;
    int errors = 0;

    logic       cap_b [200];
    logic       cap_r [200];
    logic [2:0] cap_s [200];

    // u0: 8N1, reset divisor 6 (tests load 4 at run time)
    tx_uart_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TIMER_BITS(32), .CLOCKS_PER_BAUD(6)) u0 (
        .clk(clk), .i_reset_n(rst_n), .i_valid(val[0]), .i_data(dv), .o_ready(rdy[0]),
        .i_baud_load(bl[0]), .i_baud_div(bd), .o_busy(busy[0]), .o_state(st[0]), .uart_rxd_out(rxd[0]));
    // u1: 8E1, divisor 4
    tx_uart_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .TIMER_BITS(32), .CLOCKS_PER_BAUD(4)) u1 (
        .clk(clk), .i_reset_n(rst_n), .i_valid(val[1]), .i_data(dv), .o_ready(rdy[1]),
        .i_baud_load(bl[1]), .i_baud_div(bd), .o_busy(busy[1]), .o_state(st[1]), .uart_rxd_out(rxd[1]));
    // u2: 8O1, divisor 4
    tx_uart_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .TIMER_BITS(32), .CLOCKS_PER_BAUD(4)) u2 (
        .clk(clk), .i_reset_n(rst_n), .i_valid(val[2]), .i_data(dv), .o_ready(rdy[2]),
        .i_baud_load(bl[2]), .i_baud_div(bd), .o_busy(busy[2]), .o_state(st[2]), .uart_rxd_out(rxd[2]));
    // u3: 7O2, divisor 3
    tx_uart_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .TIMER_BITS(32), .CLOCKS_PER_BAUD(3)) u3 (
        .clk(clk), .i_reset_n(rst_n), .i_valid(val[3]), .i_data(dv[6:0]), .o_ready(rdy[3]),
        .i_baud_load(bl[3]), .i_baud_div(bd), .o_busy(busy[3]), .o_state(st[3]), .uart_rxd_out(rxd[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record n cycles of one instance; valid/load strobes drop after the first edge.
    task automatic capture(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            cap_b[i] = rxd[idx];
            cap_r[i] = rdy[idx];
            cap_s[i] = st[idx];
            tick();
            val = '0;
            bl  = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (rxd !== 4'hF) begin errors++; $display("FAIL reset_line: got %b want 1111", rxd); end
        checks++;
        if (rdy !== 4'hF || busy !== 4'h0) begin
            errors++; $display("FAIL reset_ready_busy: got rdy=%b busy=%b want 1111/0000", rdy, busy);
        end
        checks++;
        if (st[0] !== 3'd0 || st[3] !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d/%0d want 0/0", st[0], st[3]);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [9:0] f;
        int first;
        bl[0] = 1'b1; bd = 32'd4; tick(); bl = '0;
        dv = 8'hA5; val[0] = 1'b1; tick(); val = '0;
        checks++;
        if (rdy[0] !== 1'b1 || busy[0] !== 1'b1 || rxd[0] !== 1'b0) begin
            errors++; $display("FAIL basic_latency: got rdy=%b busy=%b line=%b want 1 1 0", rdy[0], busy[0], rxd[0]);
        end
        capture(0, 40);
        f = {1'b1, 8'hA5, 1'b0};
        first = -1;
        for (int i = 0; i < 40; i++) if (first < 0 && cap_b[i] !== f[i/4]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL basic_frame_a5: cycle %0d got %b want %b", first, cap_b[first], f[first/4]);
        end
        checks++;
        if (cap_s[0] !== 3'd1 || cap_s[4] !== 3'd2 || cap_s[35] !== 3'd2 || cap_s[36] !== 3'd4 || cap_s[39] !== 3'd4) begin
            errors++; $display("FAIL basic_states: got %0d %0d %0d %0d %0d want 1 2 2 4 4",
                               cap_s[0], cap_s[4], cap_s[35], cap_s[36], cap_s[39]);
        end
        checks++;
        if (rxd[0] !== 1'b1 || busy[0] !== 1'b0 || st[0] !== 3'd0) begin
            errors++; $display("FAIL basic_end: got line=%b busy=%b state=%0d want 1 0 0", rxd[0], busy[0], st[0]);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  words [4];
        logic        pexp  [4];
        int          inst  [4];
        logic [10:0] f;
        int first;
        words = '{8'h07, 8'h03, 8'h07, 8'h03};
        pexp  = '{1'b1, 1'b0, 1'b0, 1'b1};
        inst  = '{1, 1, 2, 2};
        for (int k = 0; k < 4; k++) begin
            dv = words[k]; val[inst[k]] = 1'b1; tick(); val = '0;
            capture(inst[k], 44);
            f = {1'b1, pexp[k], words[k], 1'b0};
            first = -1;
            for (int i = 0; i < 44; i++) if (first < 0 && cap_b[i] !== f[i/4]) first = i;
            checks++;
            if (first >= 0) begin
                errors++; $display("FAIL parity_frame_%0d: word %h cycle %0d got %b want %b",
                                   k, words[k], first, cap_b[first], f[first/4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] f;
        int first;
        int rfirst;
        dv = 8'h55; val[0] = 1'b1; tick();
        dv = 8'hAA;
        capture(0, 80);
        f = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
        first = -1;
        rfirst = -1;
        for (int i = 0; i < 80; i++) begin
            if (first < 0 && cap_b[i] !== f[i/4]) first = i;
            if (rfirst < 0 && cap_r[i] !== (i == 0 || i >= 40)) rfirst = i;
        end
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL b2b_frames: cycle %0d got %b want %b", first, cap_b[first], f[first/4]);
        end
        checks++;
        if (rfirst >= 0) begin
            errors++; $display("FAIL b2b_ready: cycle %0d got %b want %b", rfirst, cap_r[rfirst], (rfirst == 0 || rfirst >= 40));
        end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b want 0", busy[0]); end
    endtask

    task automatic test_baud_load();
        logic [19:0] f2;
        logic [9:0]  f;
        int first;
        // Load attempt while busy: both frames stay at 4 cycles/bit
        dv = 8'h0F; val[0] = 1'b1; tick();
        bl[0] = 1'b1; bd = 32'd8; dv = 8'hF0;
        capture(0, 80);
        f2 = {1'b1, 8'hF0, 1'b0, 1'b1, 8'h0F, 1'b0};
        first = -1;
        for (int i = 0; i < 80; i++) if (first < 0 && cap_b[i] !== f2[i/4]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL baud_busy_ignored: cycle %0d got %b want %b", first, cap_b[first], f2[first/4]);
        end
        // Load 8 while idle
        bl[0] = 1'b1; bd = 32'd8; tick(); bl = '0;
        dv = 8'h3C; val[0] = 1'b1; tick(); val = '0;
        capture(0, 80);
        f = {1'b1, 8'h3C, 1'b0};
        first = -1;
        for (int i = 0; i < 80; i++) if (first < 0 && cap_b[i] !== f[i/8]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL baud_load8: cycle %0d got %b want %b", first, cap_b[first], f[first/8]);
        end
        // Load 1 is rejected; divisor stays 8
        bl[0] = 1'b1; bd = 32'd1; tick(); bl = '0;
        dv = 8'hC3; val[0] = 1'b1; tick(); val = '0;
        capture(0, 80);
        f = {1'b1, 8'hC3, 1'b0};
        first = -1;
        for (int i = 0; i < 80; i++) if (first < 0 && cap_b[i] !== f[i/8]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL baud_load1_ignored: cycle %0d got %b want %b", first, cap_b[first], f[first/8]);
        end
        // Load and accept on the same cycle: frame uses the new divisor 4
        bl[0] = 1'b1; bd = 32'd4; dv = 8'h81; val[0] = 1'b1; tick(); val = '0; bl = '0;
        capture(0, 40);
        f = {1'b1, 8'h81, 1'b0};
        first = -1;
        for (int i = 0; i < 40; i++) if (first < 0 && cap_b[i] !== f[i/4]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL baud_simultaneous: cycle %0d got %b want %b", first, cap_b[first], f[first/4]);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] f;
        int first;
        dv = 8'h5A; val[0] = 1'b1; tick();
        dv = 8'hFF; tick(); val = '0;
        checks++;
        if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got ready=%b want 0", rdy[0]); end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (st[0] !== 3'd2 || rxd[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_bit3: got state=%0d line=%b want 2 1", st[0], rxd[0]);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++;
        if (rxd[0] !== 1'b1 || st[0] !== 3'd0 || rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: got line=%b state=%0d ready=%b busy=%b want 1 0 1 0",
                               rxd[0], st[0], rdy[0], busy[0]);
        end
        capture(0, 60);
        first = -1;
        for (int i = 0; i < 60; i++) if (first < 0 && (cap_b[i] !== 1'b1 || cap_s[i] !== 3'd0)) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL rstmid_no_pending: cycle %0d got line=%b state=%0d want 1 0", first, cap_b[first], cap_s[first]);
        end
        // Divisor back at its reset value of 6
        dv = 8'h00; val[0] = 1'b1; tick(); val = '0;
        capture(0, 60);
        f = {1'b1, 8'h00, 1'b0};
        first = -1;
        for (int i = 0; i < 60; i++) if (first < 0 && cap_b[i] !== f[i/6]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL rstmid_divisor: cycle %0d got %b want %b", first, cap_b[first], f[first/6]);
        end
    endtask

    task automatic test_7o2();
        logic [10:0] f;
        int first;
        dv = 8'h00; val[3] = 1'b1; tick(); val = '0;
        capture(3, 33);
        f = {1'b1, 1'b1, 1'b1, 7'h00, 1'b0};
        first = -1;
        for (int i = 0; i < 33; i++) if (first < 0 && cap_b[i] !== f[i/3]) first = i;
        checks++;
        if (first >= 0) begin
            errors++; $display("FAIL f7o2_frame: cycle %0d got %b want %b", first, cap_b[first], f[first/3]);
        end
        checks++;
        if (cap_s[23] !== 3'd2 || cap_s[24] !== 3'd3 || cap_s[27] !== 3'd4 || cap_s[32] !== 3'd4) begin
            errors++; $display("FAIL f7o2_states: got %0d %0d %0d %0d want 2 3 4 4", cap_s[23], cap_s[24], cap_s[27], cap_s[32]);
        end
        checks++;
        if (rxd[3] !== 1'b1 || busy[3] !== 1'b0 || st[3] !== 3'd0) begin
            errors++; $display("FAIL f7o2_end: got line=%b busy=%b state=%0d want 1 0 0", rxd[3], busy[3], st[3]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        val   = '0;
        bl    = '0;
        dv    = '0;
        bd    = '0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_baud_load();
        test_reset_mid();
        test_7o2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
